// File: rtl/hex_scroll_pkg.sv
// Shared constants for the hex scroll controller: register map, CTRL bit
// positions, the blank segment pattern and the message-buffer entry layout.
package hex_scroll_pkg;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_STATUS = 2'd1,
    REG_DATA   = 2'd2,
    REG_LEN    = 2'd3
  } reg_addr_e;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_SCROLL_BIT = 1;
  localparam int CTRL_BLINK_BIT  = 2;
  localparam int CTRL_CLR_BIT    = 31;

  localparam logic [6:0] SEG_BLANK = 7'h7f;

  // One buffer entry: bit4 forces the digit blank, [3:0] is the hex nibble.
  typedef struct packed {
    logic       blank;
    logic [3:0] nibble;
  } entry_t;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder (bit6 = g ... bit0 = a).
module hex7seg
  import hex_scroll_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Glyph lookup for 0-9 and A-F.
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Avalon-MM controlled six-digit hex message display with optional scrolling.
// Optional feature: define HEX_SCROLL_BLINK_EN to implement the CTRL BLINK bit,
// which blanks the whole display on alternating pairs of scroll ticks.
// The display registers are loaded from next-state values so a state change
// is visible on HEX0..HEX5 in the cycle right after it is requested.
module hex_scroll_ctrl
  import hex_scroll_pkg::*;
#(
  parameter int TICK_DIV  = 12500000,
  parameter int BUF_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic        avs_read,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(TICK_DIV);

  logic          en_q, en_d, scroll_q, scroll_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, pos_q, pos_d;
  logic [PW:0]   len_q, len_d;
  logic [CW-1:0] presc_q, presc_d;
  logic [31:0]   readdata_q, readdata_d;
  logic [6:0]    hex_q [6];
  logic [6:0]    hex_d [6];
  logic          blink_phase_d;
  entry_t        buf_mem [BUF_DEPTH];

  logic          ctrl_wr, data_wr, clr, tick, full;
  logic [3:0]    dig_nib   [6];
  logic          dig_blank [6];
  logic [6:0]    dig_seg   [6];
  logic [31:0]   pos_ext, wr_ptr_ext;
  logic          unused_wdata;

  assign ctrl_wr      = avs_write && (avs_address == REG_CTRL);
  assign data_wr      = avs_write && (avs_address == REG_DATA);
  assign clr          = ctrl_wr && avs_writedata[CTRL_CLR_BIT];
  assign tick         = en_q && (presc_q == CW'(TICK_DIV - 1));
  assign full         = (len_q == (PW+1)'(BUF_DEPTH));
  assign pos_ext      = 32'(pos_q);
  assign wr_ptr_ext   = 32'(wr_ptr_q);
  assign unused_wdata = ^avs_writedata[30:5];

`ifdef HEX_SCROLL_BLINK_EN
  logic blink_q, blink_d, blink_cnt_q, blink_cnt_d, blink_phase_q;

  // Blink phase flips every second tick while blinking; otherwise parked at 0.
  always_comb begin
    blink_d       = ctrl_wr ? avs_writedata[CTRL_BLINK_BIT] : blink_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (clr || !en_q || !blink_q) begin
      blink_cnt_d   = 1'b0;
      blink_phase_d = 1'b0;
    end else if (tick) begin
      blink_cnt_d = ~blink_cnt_q;
      if (blink_cnt_q) blink_phase_d = ~blink_phase_q;
    end
  end

  // Blink state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      blink_q       <= 1'b0;
      blink_cnt_q   <= 1'b0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_q       <= blink_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`else
  assign blink_phase_d = 1'b0;
`endif

  // CTRL fields, write pointer, fill level and prescaler next state.
  always_comb begin
    en_d     = en_q;
    scroll_d = scroll_q;
    wr_ptr_d = wr_ptr_q;
    len_d    = len_q;
    if (ctrl_wr) begin
      en_d     = avs_writedata[CTRL_EN_BIT];
      scroll_d = avs_writedata[CTRL_SCROLL_BIT];
    end
    if (clr) begin
      wr_ptr_d = '0;
      len_d    = '0;
    end else if (data_wr) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (!full) len_d = len_q + 1'b1;
    end
    if (!en_q || tick) presc_d = '0;
    else               presc_d = presc_q + 1'b1;
  end

  // Scroll position: a clear beats a tick; parked at 0 whenever scrolling is idle.
  always_comb begin
    pos_d = pos_q;
    if (clr || !scroll_q || !en_q || (len_q == '0)) begin
      pos_d = '0;
    end else if (tick) begin
      if ({1'b0, pos_q} == len_q - 1'b1) pos_d = '0;
      else                               pos_d = pos_q + 1'b1;
    end
  end

  // Register read mux; readdata holds its value between reads.
  always_comb begin
    readdata_d = readdata_q;
    if (avs_read) begin
      readdata_d = '0;
      case (avs_address)
        REG_CTRL: begin
          readdata_d[CTRL_EN_BIT]     = en_q;
          readdata_d[CTRL_SCROLL_BIT] = scroll_q;
`ifdef HEX_SCROLL_BLINK_EN
          readdata_d[CTRL_BLINK_BIT]  = blink_q;
`endif
        end
        REG_STATUS: begin
          readdata_d[11:8] = pos_ext[3:0];
          readdata_d[7:4]  = wr_ptr_ext[3:0];
          readdata_d[0]    = full;
        end
        REG_LEN:  readdata_d = 32'(len_q);
        default:  readdata_d = '0;
      endcase
    end
  end

  // Pick the entry for each digit (leftmost first), bypassing a same-cycle DATA write.
  always_comb begin
    logic [PW-1:0] idx;
    logic [PW-1:0] sel;
    logic          show;
    entry_t        ent;
    idx = pos_d;
    for (int j = 0; j < 6; j++) begin
      sel  = scroll_d ? idx : PW'(j);
      show = scroll_d ? 1'b1 : (j < int'(len_d));
      ent  = (data_wr && (sel == wr_ptr_q)) ? entry_t'(avs_writedata[4:0]) : buf_mem[sel];
      dig_nib[j]   = ent.nibble;
      dig_blank[j] = ent.blank || !en_d || (len_d == '0) || blink_phase_d || !show;
      if ({1'b0, idx} == len_d - 1'b1) idx = '0;
      else                             idx = idx + 1'b1;
    end
  end

  for (genvar g = 0; g < 6; g++) begin : g_seg
    hex7seg u_hex7seg (
      .nibble (dig_nib[g]),
      .seg    (dig_seg[g])
    );
  end

  // Leftmost digit position j drives HEX(5-j); blanked digits show all segments off.
  always_comb begin
    for (int j = 0; j < 6; j++) begin
      hex_d[5-j] = dig_blank[j] ? SEG_BLANK : dig_seg[j];
    end
  end

  // Message buffer storage; contents survive reset and clear.
  always_ff @(posedge CLK) begin
    if (data_wr) buf_mem[wr_ptr_q] <= entry_t'(avs_writedata[4:0]);
  end

  // Control and display state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      en_q       <= 1'b0;
      scroll_q   <= 1'b0;
      wr_ptr_q   <= '0;
      len_q      <= '0;
      pos_q      <= '0;
      presc_q    <= '0;
      readdata_q <= '0;
      for (int k = 0; k < 6; k++) hex_q[k] <= SEG_BLANK;
    end else begin
      en_q       <= en_d;
      scroll_q   <= scroll_d;
      wr_ptr_q   <= wr_ptr_d;
      len_q      <= len_d;
      pos_q      <= pos_d;
      presc_q    <= presc_d;
      readdata_q <= readdata_d;
      for (int k = 0; k < 6; k++) hex_q[k] <= hex_d[k];
    end
  end

  assign avs_readdata = readdata_q;
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Directed self-checking bench for hex_scroll_ctrl with a 4-cycle scroll tick.
module tb_hex_scroll_ctrl;
  import hex_scroll_pkg::*;

  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [41:0] ALL_BLANK = {6{7'h7f}};

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_write = 1'b0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [41:0] hexBus;
  logic [31:0] rd;
  int          checks = 0;
  int          errors = 0;

  assign hexBus = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  hex_scroll_ctrl #(.TICK_DIV(4), .BUF_DEPTH(16)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_read      (avs_read),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .HEX0          (HEX0),
    .HEX1          (HEX1),
    .HEX2          (HEX2),
    .HEX3          (HEX3),
    .HEX4          (HEX4),
    .HEX5          (HEX5)
  );

  always #5 CLK = ~CLK;

  // One-cycle register write; returns 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    @(posedge CLK); #1;
    avs_write     = 1'b0;
  endtask

  task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
    avs_address = addr;
    avs_read    = 1'b1;
    @(posedge CLK); #1;
    avs_read    = 1'b0;
    data        = avs_readdata;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset state
    stepCycles(3);
    checkOutput("reset_hex", hexBus, ALL_BLANK);
    checkOutput("reset_rdata", avs_readdata, 32'h0);
    RST = 1'b0;
    readReg(REG_CTRL, rd);
    checkOutput("reset_ctrl", rd, 32'h0);
    readReg(REG_STATUS, rd);
    checkOutput("reset_status", rd, 32'h0);

    // Static display of three entries
    applyStimulus(REG_CTRL, 32'h1);
    applyStimulus(REG_DATA, 32'h1);
    applyStimulus(REG_DATA, 32'h2);
    applyStimulus(REG_DATA, 32'h3);
    checkOutput("static_123", hexBus, {7'h79, 7'h24, 7'h30, 7'h7f, 7'h7f, 7'h7f});
    applyStimulus(REG_CTRL, 32'h0);
    checkOutput("en_off_blank", hexBus, ALL_BLANK);
    applyStimulus(REG_CTRL, 32'h1);
    applyStimulus(REG_DATA, 32'h1E);
    applyStimulus(REG_DATA, 32'hFFFF_FFE5);
    checkOutput("static_blankbit", hexBus, {7'h79, 7'h24, 7'h30, 7'h7f, 7'h12, 7'h7f});
    readReg(REG_LEN, rd);
    checkOutput("len_5", rd, 32'd5);
    applyStimulus(REG_CTRL, 32'h8000_0000);
    checkOutput("clr_hex", hexBus, ALL_BLANK);
    readReg(REG_LEN, rd);
    checkOutput("clr_len", rd, 32'd0);
    readReg(REG_CTRL, rd);
    checkOutput("clr_reads_0", rd, 32'h0);

    // Scrolling through eight entries, one step per 4 cycles
    for (int i = 0; i < 8; i++) applyStimulus(REG_DATA, 32'(i));
    applyStimulus(REG_CTRL, 32'h3);
    checkOutput("scroll_pos0", hexBus, {SEG[0], SEG[1], SEG[2], SEG[3], SEG[4], SEG[5]});
    stepCycles(4);
    checkOutput("scroll_pos1", hexBus, {SEG[1], SEG[2], SEG[3], SEG[4], SEG[5], SEG[6]});
    for (int k = 1; k <= 8; k++) begin
      checkOutput($sformatf("scroll_hex5_%0d", k), HEX5, SEG[k % 8]);
      readReg(REG_STATUS, rd);
      checkOutput($sformatf("scroll_status_%0d", k), rd, 32'(((k % 8) << 8) | 32'h80));
      stepCycles(3);
    end

    // CLR lands on the same edge as a tick (pos would otherwise go 1 -> 2)
    stepCycles(3);
    applyStimulus(REG_CTRL, 32'h8000_0003);
    checkOutput("clr_tick_hex", hexBus, ALL_BLANK);
    readReg(REG_STATUS, rd);
    checkOutput("clr_tick_status", rd, 32'h0);
    readReg(REG_LEN, rd);
    checkOutput("clr_tick_len", rd, 32'd0);

    // Scrolling with fewer entries than digits repeats the message
    applyStimulus(REG_CTRL, 32'h2);
    applyStimulus(REG_DATA, 32'h1);
    applyStimulus(REG_DATA, 32'h2);
    applyStimulus(REG_DATA, 32'h3);
    applyStimulus(REG_CTRL, 32'h3);
    checkOutput("short_pos0", hexBus, {7'h79, 7'h24, 7'h30, 7'h79, 7'h24, 7'h30});
    stepCycles(4);
    checkOutput("short_pos1", hexBus, {7'h24, 7'h30, 7'h79, 7'h24, 7'h30, 7'h79});

    // Overfilling the buffer overwrites the oldest entry
    applyStimulus(REG_CTRL, 32'h8000_0000);
    for (int i = 0; i < 16; i++) applyStimulus(REG_DATA, 32'(i));
    applyStimulus(REG_DATA, 32'h9);
    readReg(REG_LEN, rd);
    checkOutput("full_len", rd, 32'd16);
    readReg(REG_STATUS, rd);
    checkOutput("full_status", rd, 32'h011);
    applyStimulus(REG_DATA, 32'hA);
    applyStimulus(REG_LEN, 32'h0);
    applyStimulus(REG_STATUS, 32'hFFFF);
    readReg(REG_LEN, rd);
    checkOutput("ro_len", rd, 32'd16);
    applyStimulus(REG_CTRL, 32'h1);
    checkOutput("full_static", hexBus, {7'h10, 7'h08, 7'h24, 7'h30, 7'h19, 7'h12});

    // Blink control
    applyStimulus(REG_CTRL, 32'h0);
    applyStimulus(REG_CTRL, 32'h5);
`ifdef HEX_SCROLL_BLINK_EN
    checkOutput("blink_on_a", hexBus, {7'h10, 7'h08, 7'h24, 7'h30, 7'h19, 7'h12});
    stepCycles(7);
    checkOutput("blink_on_b", hexBus, {7'h10, 7'h08, 7'h24, 7'h30, 7'h19, 7'h12});
    stepCycles(1);
    checkOutput("blink_off_a", hexBus, ALL_BLANK);
    stepCycles(7);
    checkOutput("blink_off_b", hexBus, ALL_BLANK);
    stepCycles(1);
    checkOutput("blink_on_c", hexBus, {7'h10, 7'h08, 7'h24, 7'h30, 7'h19, 7'h12});
    readReg(REG_CTRL, rd);
    checkOutput("blink_ctrl", rd, 32'h5);
`else
    checkOutput("noblink_hex", hexBus, {7'h10, 7'h08, 7'h24, 7'h30, 7'h19, 7'h12});
    stepCycles(8);
    checkOutput("noblink_hex_b", hexBus, {7'h10, 7'h08, 7'h24, 7'h30, 7'h19, 7'h12});
    readReg(REG_CTRL, rd);
    checkOutput("noblink_ctrl", rd, 32'h1);
`endif

    // Reset in the middle of scrolling at pos 5, with a read in the same cycle
    applyStimulus(REG_CTRL, 32'h0);
    applyStimulus(REG_CTRL, 32'h3);
    stepCycles(20);
    readReg(REG_STATUS, rd);
    checkOutput("pos5_status", rd, 32'h521);
    stepCycles(1);
    checkOutput("rdata_hold", avs_readdata, 32'h521);
    RST         = 1'b1;
    avs_read    = 1'b1;
    avs_address = REG_STATUS;
    @(posedge CLK); #1;
    RST      = 1'b0;
    avs_read = 1'b0;
    checkOutput("rst_rdata", avs_readdata, 32'h0);
    checkOutput("rst_hex", hexBus, ALL_BLANK);
    readReg(REG_STATUS, rd);
    checkOutput("rst_status", rd, 32'h0);
    readReg(REG_LEN, rd);
    checkOutput("rst_len", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
